// File: rtl/grf_mp.sv
// Dual-write, dual-read register file with bypass, per-register busy scoreboard
// and a write-trace FIFO with a saturating drop counter.
module grf_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int TRD      = 4,
  parameter int ZERO_REG = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] WA0,
  input  logic [AW-1:0] WA1,
  input  logic [DW-1:0] WD0,
  input  logic [DW-1:0] WD1,
  input  logic [31:0]   WPC0,
  input  logic [31:0]   WPC1,
  input  logic          IssueEn,
  input  logic [AW-1:0] IssueA,
  output logic          Busy1,
  output logic          Busy2,
  output logic          TrValid,
  input  logic          TrReady,
  output logic [31:0]   TrPC,
  output logic [AW-1:0] TrAddr,
  output logic [DW-1:0] TrData,
  output logic [7:0]    TrDrop
);
  localparam int NREG = 1 << AW;
  localparam int PW   = $clog2(TRD);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic [31:0]   pc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } tr_t;

  logic [DW-1:0]         rf [NREG];
  logic [NREG-1:0]       busy;
  logic [1:0]            eff;
  logic [1:0][AW-1:0]    ra;
  logic [1:0][DW-1:0]    rd;
  logic [1:0]            bz;

  // Port 1 wins a same-address collision, so port 0 is squashed entirely.
  assign eff[1] = WE1 & Rst_n & ~((ZERO_REG != 0) && (WA1 == '0));
  assign eff[0] = WE0 & Rst_n & ~((ZERO_REG != 0) && (WA0 == '0))
                  & ~(eff[1] && (WA0 == WA1));

  assign ra = {A2, A1};

  always_comb begin
    rd = '0;
    bz = '0;
    for (int r = 0; r < 2; r++) begin
      if ((ZERO_REG != 0) && (ra[r] == '0)) rd[r] = '0;
      else if (eff[1] && (WA1 == ra[r]))    rd[r] = WD1;
      else if (eff[0] && (WA0 == ra[r]))    rd[r] = WD0;
      else                                  rd[r] = rf[ra[r]];
      bz[r] = (ra[r] == '0) ? 1'b0 : busy[ra[r]];
    end
  end

  assign RD1   = rd[0];
  assign RD2   = rd[1];
  assign Busy1 = bz[0];
  assign Busy2 = bz[1];

  // Issue is applied after the write-clear so a same-cycle issue leaves the bit set.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (eff[0]) rf[WA0] <= WD0;
      if (eff[1]) rf[WA1] <= WD1;
      for (int i = 0; i < NREG; i++) begin
        if (IssueEn && (IssueA != '0) && (IssueA == AW'(i)))
          busy[i] <= 1'b1;
        else if ((eff[0] && (WA0 == AW'(i))) || (eff[1] && (WA1 == AW'(i))))
          busy[i] <= 1'b0;
      end
    end
  end

  tr_t            mem [TRD];
  tr_t            ent0, ent1, first, head;
  logic [PW-1:0]  rptr, wptr;
  logic [CW-1:0]  cnt;
  logic           pop;
  logic [1:0]     npush, acc, ndrop;
  logic [CW:0]    room;
  logic [8:0]     drop_sum;

  assign ent0     = '{pc: WPC0, addr: WA0, data: WD0};
  assign ent1     = '{pc: WPC1, addr: WA1, data: WD1};
  assign TrValid  = (cnt != '0);
  assign pop      = TrValid & TrReady;
  assign npush    = {1'b0, eff[0]} + {1'b0, eff[1]};
  // A same-cycle pop frees a slot for this cycle's pushes.
  assign room     = (CW+1)'(TRD) - {1'b0, cnt} + {{CW{1'b0}}, pop};
  assign acc      = (room >= {{(CW-1){1'b0}}, npush}) ? npush : room[1:0];
  assign ndrop    = npush - acc;
  assign first    = eff[0] ? ent0 : ent1;
  assign drop_sum = {1'b0, TrDrop} + {7'b0, ndrop};

  always_ff @(posedge Clk) begin
    if (acc != 2'd0) mem[wptr] <= first;
    if (acc == 2'd2) mem[wptr + PW'(1)] <= ent1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rptr   <= '0;
      wptr   <= '0;
      cnt    <= '0;
      TrDrop <= '0;
    end else begin
      wptr   <= wptr + PW'(acc);
      rptr   <= rptr + PW'(pop);
      cnt    <= cnt + CW'(acc) - CW'(pop);
      TrDrop <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign head   = mem[rptr];
  assign TrPC   = head.pc;
  assign TrAddr = head.addr;
  assign TrData = head.data;
endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a queue/array reference model.
module tb_grf_mp;
  localparam int DW = 32, AW = 5, TRD = 4, NREG = 32;

  logic          Clk = 1'b0, Rst_n = 1'b0;
  logic [AW-1:0] A1 = '0, A2 = '0, WA0 = '0, WA1 = '0, IssueA = '0, TrAddr;
  logic [DW-1:0] RD1, RD2, WD0 = '0, WD1 = '0, TrData;
  logic          WE0 = 1'b0, WE1 = 1'b0, IssueEn = 1'b0, TrReady = 1'b0;
  logic [31:0]   WPC0 = '0, WPC1 = '0, TrPC;
  logic          Busy1, Busy2, TrValid;
  logic [7:0]    TrDrop;

  always #5 Clk = ~Clk;

  grf_mp #(.DW(DW), .AW(AW), .TRD(TRD), .ZERO_REG(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .WE0(WE0), .WE1(WE1), .WA0(WA0), .WA1(WA1), .WD0(WD0), .WD1(WD1),
    .WPC0(WPC0), .WPC1(WPC1), .IssueEn(IssueEn), .IssueA(IssueA),
    .Busy1(Busy1), .Busy2(Busy2), .TrValid(TrValid), .TrReady(TrReady),
    .TrPC(TrPC), .TrAddr(TrAddr), .TrData(TrData), .TrDrop(TrDrop));

  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays and a queue.
  typedef struct { logic [31:0] pc; logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  logic [DW-1:0] m_rf [NREG];
  bit            m_busy [NREG];
  ent_t          m_q [$];
  int            m_drop = 0;
  bit            m_live = 0;

  function automatic bit e1();
    return WE1 && Rst_n && (WA1 != 0);
  endfunction
  function automatic bit e0();
    return WE0 && Rst_n && (WA0 != 0) && !(e1() && WA0 == WA1);
  endfunction
  function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (e1() && WA1 == a) return WD1;
    if (e0() && WA0 == a) return WD0;
    return m_rf[a];
  endfunction

  task automatic m_push(logic [31:0] pc, logic [AW-1:0] a, logic [DW-1:0] d);
    ent_t e;
    e.pc = pc; e.a = a; e.d = d;
    if (m_q.size() < TRD) m_q.push_back(e);
    else if (m_drop < 255) m_drop++;
  endtask

  always @(posedge Clk) begin
    bit w0, w1;
    w0 = e0();
    w1 = e1();
    if (!Rst_n) begin
      foreach (m_rf[i]) begin m_rf[i] = '0; m_busy[i] = 0; end
      m_q.delete();
      m_drop = 0;
      m_live = 1;
    end else begin
      if (m_q.size() > 0 && TrReady) void'(m_q.pop_front());
      if (w0) m_push(WPC0, WA0, WD0);
      if (w1) m_push(WPC1, WA1, WD1);
      if (w0) begin m_rf[WA0] = WD0; m_busy[WA0] = 0; end
      if (w1) begin m_rf[WA1] = WD1; m_busy[WA1] = 0; end
      if (IssueEn && IssueA != 0) m_busy[IssueA] = 1;
    end
  end

  always @(negedge Clk) begin
    if (m_live) begin
      chk("rd1", RD1, exp_rd(A1));
      chk("rd2", RD2, exp_rd(A2));
      chk("busy1", Busy1, (A1 != 0) && m_busy[A1]);
      chk("busy2", Busy2, (A2 != 0) && m_busy[A2]);
      chk("trvalid", TrValid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("trpc", TrPC, m_q[0].pc);
        chk("traddr", TrAddr, m_q[0].a);
        chk("trdata", TrData, m_q[0].d);
      end
      chk("trdrop", TrDrop, m_drop);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
    WE0 = 0; WE1 = 0; IssueEn = 0;
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1;
    #1;
    chk("rst_trvalid", TrValid, 0);
    chk("rst_trdrop", TrDrop, 0);
    chk("rst_busy1", Busy1, 0);

    // write then read, bypass and registered
    WE0 = 1; WA0 = 3; WD0 = 32'h12345678; WPC0 = 32'h100; A1 = 3;
    #1 chk("bypass_rd1", RD1, 32'h12345678);
    step(); #1;
    chk("rf_rd1", RD1, 32'h12345678);
    chk("tr_addr3", TrAddr, 3);
    chk("tr_pc100", TrPC, 32'h100);
    TrReady = 1; step(); TrReady = 0; #1;
    chk("drain1", TrValid, 0);

    // same-address dual write
    WE0 = 1; WE1 = 1; WA0 = 5; WA1 = 5; WD0 = 32'hA; WD1 = 32'hB;
    WPC0 = 32'h200; WPC1 = 32'h204; A1 = 5;
    #1 chk("same_bypass", RD1, 32'hB);
    step(); #1;
    chk("same_rf", RD1, 32'hB);
    chk("same_trdata", TrData, 32'hB);
    chk("same_trpc", TrPC, 32'h204);
    TrReady = 1; step(); TrReady = 0; #1;
    chk("same_one_entry", TrValid, 0);

    // zero register
    WE0 = 1; WA0 = 0; WD0 = 32'hFFFF_FFFF; A1 = 0;
    #1 chk("zero_rd1", RD1, 0);
    step(); #1;
    chk("zero_nopush", TrValid, 0);
    chk("zero_nodrop", TrDrop, 0);

    // scoreboard
    TrReady = 1;
    IssueEn = 1; IssueA = 7; A1 = 7;
    step(); #1 chk("busy_set", Busy1, 1);
    IssueEn = 1; IssueA = 7; WE0 = 1; WA0 = 7; WD0 = 32'h77;
    step(); #1 chk("busy_issue_wins", Busy1, 1);
    WE0 = 1; WA0 = 7; WD0 = 32'h78;
    step(); #1 chk("busy_clear", Busy1, 0);
    step(); TrReady = 0; #1;
    chk("sb_drained", TrValid, 0);

    // overflow
    for (int i = 0; i < 3; i++) begin
      WE0 = 1; WA0 = AW'(10 + 2*i); WD0 = 32'h100 + 2*i; WPC0 = 32'h1000 + 8*i;
      WE1 = 1; WA1 = AW'(11 + 2*i); WD1 = 32'h101 + 2*i; WPC1 = 32'h1004 + 8*i;
      step();
    end
    #1 chk("ovf_drop", TrDrop, 2);
    TrReady = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ovf_order_addr", TrAddr, 10 + i);
      chk("ovf_order_data", TrData, 32'h100 + i);
      step();
    end
    #1 chk("ovf_empty", TrValid, 0);
    TrReady = 0;

    // reset mid-stream
    WE0 = 1; WA0 = 9; WD0 = 32'h55; WE1 = 1; WA1 = 20; WD1 = 32'h1;
    IssueEn = 1; IssueA = 4;
    step();
    WE0 = 1; WA0 = 21; WD0 = 32'h2;
    step();
    A1 = 4; A2 = 9;
    #1 chk("pre_rst_rd2", RD2, 32'h55);
    chk("pre_rst_busy1", Busy1, 1);
    Rst_n = 0;
    step();
    Rst_n = 1;
    #1 chk("mid_rst_trvalid", TrValid, 0);
    chk("mid_rst_rf9", RD2, 0);
    chk("mid_rst_trdrop", TrDrop, 0);
    chk("mid_rst_busy1", Busy1, 0);

    // random phase, checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      @(posedge Clk);
      #1;
      Rst_n   = ($urandom_range(0, 149) != 0);
      WE0     = $urandom_range(0, 1);
      WE1     = $urandom_range(0, 1);
      WA0     = raddr();
      WA1     = raddr();
      WD0     = $urandom;
      WD1     = $urandom;
      WPC0    = $urandom;
      WPC1    = $urandom;
      IssueEn = ($urandom_range(0, 2) == 0);
      IssueA  = raddr();
      A1      = raddr();
      A2      = raddr();
      TrReady = ($urandom_range(0, 3) == 0);
    end
    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grf_mp.md
GRF_MP -- requirements
Module: grf_mp

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter AW, default 5, meaning address width; register count NREG = 2^AW.
REQ-003 SHALL have parameter TRD, default 4, meaning trace FIFO depth in entries; power of two, at least 2.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have port Clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port Rst_n  in  1  reset, synchronous and active-low (one clock; reset is synchronous and active-low).
REQ-007 SHALL have ports A1, A2  in  AW  read addresses.
REQ-008 SHALL have ports RD1, RD2  out  DW  read data.
REQ-009 SHALL have ports WE0, WE1  in  1  write enables, port 0 and port 1.
REQ-010 SHALL have ports WA0, WA1  in  AW  write addresses.
REQ-011 SHALL have ports WD0, WD1  in  DW  write data.
REQ-012 SHALL have ports WPC0, WPC1  in  32  PC tag of each write, used for the trace only.
REQ-013 SHALL have ports IssueEn  in  1  and IssueA  in  AW, which mark a register busy (pending result).
REQ-014 SHALL have ports Busy1, Busy2  out  1  giving the busy state of A1 and A2.
REQ-015 SHALL have ports TrValid  out  1  and TrReady  in  1, the trace handshake.
REQ-016 SHALL have ports TrPC  out  32, TrAddr  out  AW and TrData  out  DW, the head trace entry.
REQ-017 SHALL have port TrDrop  out  8  saturating count of trace entries lost.

Function
REQ-018 Effective write on port k: WEk=1, Rst_n=1, and not (ZERO_REG=1 and WAk=0).
- SHALL update rf[WAk] <= WDk at the clock edge.
REQ-019 Both ports writing the same address in one cycle:
- port 1 SHALL win.
- port 0's write SHALL be discarded and is not an effective write.
REQ-020 RDn SHALL be combinational, evaluated in this order:
- 0 if ZERO_REG=1 and An=0.
- else WD1 if port 1 is effectively writing An.
- else WD0 if port 0 is effectively writing An.
- else rf[An].
REQ-021 Busy state: one busy bit per register; IssueEn with IssueA≠0 SHALL set busy[IssueA] at the edge.
REQ-022 An effective write SHALL clear busy[WAk].
REQ-023 Issue and write to the same address in the same cycle: busy SHALL end set (issue wins).
REQ-024 Busy1/Busy2 SHALL reflect the registered busy bits only, with no bypass; busy[0] SHALL read 0.
REQ-025 Trace push: each effective write SHALL request a push of {WPCk, WAk, WDk}; when both push, port 0 is enqueued first.
REQ-026 Trace pop: pop occurs when TrValid=1 and TrReady=1.
- Free slots for pushes SHALL include the slot released by a same-cycle pop.
REQ-027 Overflow: pushes that do not fit SHALL be dropped.
- Pushes are accepted in port order until the FIFO is full.
- TrDrop SHALL increase by the number dropped (0–2) and saturate at 255.
REQ-028 TrValid SHALL be 1 exactly when the FIFO is non-empty.
- TrPC/TrAddr/TrData SHALL show the oldest entry and stay stable while TrValid=1 and TrReady=0.
REQ-029 FIFO pointers SHALL wrap modulo TRD; occupancy SHALL never exceed TRD.

Reset
REQ-030 While Rst_n=0 at an edge, every rf entry SHALL become 0.
- All busy bits SHALL become 0.
- The FIFO SHALL become empty (TrValid=0).
- TrDrop SHALL become 0.
REQ-031 While Rst_n=0, writes and issues SHALL be ignored and produce no trace entries.
REQ-032 Reset asserted mid-operation SHALL discard all queued trace entries; there SHALL be no asynchronous effect.
REQ-033 Simulation initial state SHALL equal the reset state.

Verification
REQ-034 Write then read: WE0=1, WA0=3, WD0=0x12345678 -> RD1 (A1=3) = 0x12345678 in the same cycle via bypass and after the edge from rf.
REQ-035 Same-address write: WE0/WE1 both to $5 with WD0=0xA, WD1=0xB -> rf[5]=0xB and exactly one trace entry {WPC1, 5, 0xB}.
REQ-036 Zero register: WE0=1, WA0=0, WD0=0xFFFF_FFFF -> RD1 (A1=0) = 0, no trace push, TrDrop unchanged.
REQ-037 Scoreboard: issue $7 -> Busy1 (A1=7) = 1 next cycle; issue $7 and write $7 in the same cycle -> Busy1 stays 1; a later write to $7 alone -> Busy1 = 0.
REQ-038 Overflow: TRD=4, TrReady=0, three dual-write cycles to distinct registers -> 4 entries held, TrDrop=2; then TrReady=1 -> entries pop in write order.
REQ-039 Reset mid-stream: FIFO holding 3 entries, rf[9]=0x55, Rst_n=0 for one edge -> TrValid=0, rf[9]=0, TrDrop=0, Busy outputs 0.
